ysyx_23060077_lsu_axi_master: RTL and testbench
===============================================

# ysyx_23060077_lsu_axi_master

Bridge between the LSU request interface and an AXI4 master port. It accepts one level-held read or write request from the LSU at a time and performs a single-beat AXI4 transaction. It lane-aligns write data to the bus and generates the byte strobes, and right-justifies read data before returning it. It sits between `ysyx_23060077_lsu` and the core's memory arbiter/crossbar, acting as responder to the LSU and initiator on AXI.

## Interface
- DATA_WIDTH, 32, LSU and AXI data width.
- ADDR_WIDTH, 32, address width.
- Clocking and reset: clock is `clock`; reset is `reset`, synchronous, active-high.
- clock  in  1  clock
- reset  in  1  synchronous active-high reset
- lsu_r_valid_i  in  1  read request, held high until the LSU sees completion
- lsu_r_addr_i  in  ADDR_WIDTH  byte address
- lsu_r_size_i  in  3  0 = byte, 1 = half, 2 = word
- lsu_r_len_i  in  8  always 0; ignored
- lsu_r_ready_o / lsu_r_last_o  out  1 / 1  one-cycle completion pulse, both high together
- lsu_r_data_o  out  DATA_WIDTH  right-justified read data, valid during the pulse
- lsu_w_valid_i, lsu_w_addr_i, lsu_w_size_i, lsu_w_len_i  in  1, ADDR_WIDTH, 3, 8  write request, same semantics as the read request
- lsu_w_data_i  in  DATA_WIDTH  write data, right-justified (unshifted)
- lsu_w_ready_o  out  1  one-cycle pulse on the W handshake
- lsu_w_last_o  out  1  one-cycle write completion pulse
- access_fault_o  out  1  pulses together with a completion when RRESP/BRESP != 0
- axi_arvalid_o, axi_arready_i, axi_araddr_o, axi_arsize_o[2:0], axi_arlen_o[7:0]  AR channel
- axi_rvalid_i, axi_rready_o, axi_rdata_i, axi_rresp_i[1:0], axi_rlast_i  R channel
- axi_awvalid_o, axi_awready_i, axi_awaddr_o, axi_awsize_o[2:0], axi_awlen_o[7:0]  AW channel
- axi_wvalid_o, axi_wready_i, axi_wdata_o, axi_wstrb_o[3:0], axi_wlast_o  W channel
- axi_bvalid_i, axi_bready_o, axi_bresp_i[1:0]  B channel

## Operation
- States: IDLE, AR, R, RRESP, AWW, B, BRESP.
- **IDLE**
  - If lsu_r_valid_i: latch addr and size, go to AR.
  - Else if lsu_w_valid_i: latch addr, size and data, build the lane-aligned write data and strobe, go to AWW.
  - Read wins if both requests are high.
- **AR**
  - arvalid=1 with latched addr/size; arlen=0.
  - On arready: go to R.
- **R**
  - rready=1.
  - On rvalid: latch data = rdata >> (8*addr[1:0]) and latch rresp, go to RRESP.
  - rlast is expected high; it is not checked.
- **RRESP**
  - lsu_r_ready_o = lsu_r_last_o = 1 for one cycle; access_fault_o = (rresp != 0).
  - Go to IDLE.
- **AWW**
  - awvalid and wvalid are both raised in the same cycle; wlast=1.
  - Each channel drops independently after its own handshake, tracked by aw_done/w_done flags.
  - lsu_w_ready_o pulses in the W handshake cycle.
  - When both handshakes are done (they may complete in the same cycle): go to B.
- **B**
  - bready=1.
  - On bvalid: latch bresp, go to BRESP.
- **BRESP**
  - lsu_w_last_o=1 for one cycle; access_fault_o = (bresp != 0).
  - Go to IDLE.
- Write lane rules:
  - wdata = data << (8*addr[1:0]).
  - wstrb: size 0 → 4'b0001 << addr[1:0]; size 1 → 4'b0011 << addr[1:0]; size 2 → 4'b1111.
  - Size 3..7 is treated as size 2.
- Misaligned half/word accesses are issued unsplit. The result is undefined, and the bench flags them with an assertion.
- AXI valid outputs never drop before their handshake.

## Timing
- Reset value of every output, and of all internal registers, is 0; state resets to IDLE.
- Reset asserted mid-transaction: return to IDLE next edge with all valids low. The downstream slave shares the reset.
- Read, zero-wait slave:
  - cycle 0: lsu_r_valid_i high.
  - cycle 1: arvalid, arready.
  - cycle 2: rready, rvalid.
  - cycle 3: completion pulse.
  - Minimum latency is 3 cycles; each slave stall adds one cycle.
- Write, zero-wait slave:
  - cycle 1: awvalid, wvalid, both readies.
  - cycle 2: bready, bvalid.
  - cycle 3: lsu_w_last_o.
- The request is still high during the completion cycle and is sampled low in the following IDLE cycle. The bridge must not re-issue in the completion cycle.
- All AXI outputs are registered or derived from state only; none depend combinationally on LSU inputs.

## Test plan
- **lb at 0x8000_0003**, memory word 0xAABBCCDD, zero wait → arsize=0, lsu_r_data_o=0x0000_00AA, pulse in cycle 3.
- **sh of 0x1234 at 0x8000_0002** → awaddr=0x8000_0002, wdata=0x1234_0000, wstrb=4'b1100, wlast=1, lsu_w_last_o in cycle 3.
- **Stalls: arready late 2 cycles, rvalid late 3 cycles** → arvalid held steady, completion in cycle 8, exactly one pulse.
- **Write with awready at cycle 1 and wready at cycle 4** → awvalid drops after cycle 1, wvalid is held until cycle 4, lsu_w_ready_o pulses once at cycle 4, B is entered at cycle 5.
- **rresp=2'b10 on lw** → completion pulse with access_fault_o=1. Next request proceeds normally.
- **Reset asserted while in R**, then lw issued → all valids 0 after the edge; the new request completes correctly from IDLE.

Source files
------------

// File: rtl/ysyx_23060077_lsu_axi_master.sv
// LSU-to-AXI4 bridge: one outstanding single-beat read or write at a time.
// Write data is lane-aligned with byte strobes on the way out.
// Read data is right-justified on the way back.
module ysyx_23060077_lsu_axi_master #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  // LSU read request
  input  logic                    lsu_r_valid_i,
  input  logic [ADDR_WIDTH-1:0]   lsu_r_addr_i,
  input  logic [2:0]              lsu_r_size_i,
  input  logic [7:0]              lsu_r_len_i,
  output logic                    lsu_r_ready_o,
  output logic                    lsu_r_last_o,
  output logic [DATA_WIDTH-1:0]   lsu_r_data_o,
  // LSU write request
  input  logic                    lsu_w_valid_i,
  input  logic [ADDR_WIDTH-1:0]   lsu_w_addr_i,
  input  logic [2:0]              lsu_w_size_i,
  input  logic [7:0]              lsu_w_len_i,
  input  logic [DATA_WIDTH-1:0]   lsu_w_data_i,
  output logic                    lsu_w_ready_o,
  output logic                    lsu_w_last_o,
  output logic                    access_fault_o,
  // AXI AR
  output logic                    axi_arvalid_o,
  input  logic                    axi_arready_i,
  output logic [ADDR_WIDTH-1:0]   axi_araddr_o,
  output logic [2:0]              axi_arsize_o,
  output logic [7:0]              axi_arlen_o,
  // AXI R
  input  logic                    axi_rvalid_i,
  output logic                    axi_rready_o,
  input  logic [DATA_WIDTH-1:0]   axi_rdata_i,
  input  logic [1:0]              axi_rresp_i,
  input  logic                    axi_rlast_i,
  // AXI AW
  output logic                    axi_awvalid_o,
  input  logic                    axi_awready_i,
  output logic [ADDR_WIDTH-1:0]   axi_awaddr_o,
  output logic [2:0]              axi_awsize_o,
  output logic [7:0]              axi_awlen_o,
  // AXI W
  output logic                    axi_wvalid_o,
  input  logic                    axi_wready_i,
  output logic [DATA_WIDTH-1:0]   axi_wdata_o,
  output logic [DATA_WIDTH/8-1:0] axi_wstrb_o,
  output logic                    axi_wlast_o,
  // AXI B
  input  logic                    axi_bvalid_i,
  output logic                    axi_bready_o,
  input  logic [1:0]              axi_bresp_i
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);

  typedef enum logic [2:0] {
    S_IDLE, S_AR, S_R, S_RRESP, S_AWW, S_B, S_BRESP
  } state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [2:0]            size_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     wstrb_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            resp_q;
  logic                  aw_done_q;
  logic                  w_done_q;

  logic [OFF_W-1:0]      w_off;
  logic [STRB_W-1:0]     wstrb_c;
  logic                  aw_hs;
  logic                  w_hs;
  logic                  aww_done;

  // Burst length and rlast carry no information for single-beat traffic.
  logic unused_ok;
  assign unused_ok = ^{lsu_r_len_i, lsu_w_len_i, axi_rlast_i};

  // Sizes wider than the bus are issued as a full-width access.
  function automatic logic [2:0] clamp_size(input logic [2:0] s);
    return (s > 3'd2) ? 3'd2 : s;
  endfunction

  assign w_off    = lsu_w_addr_i[OFF_W-1:0];
  assign aw_hs    = axi_awvalid_o && axi_awready_i;
  assign w_hs     = axi_wvalid_o && axi_wready_i;
  assign aww_done = (aw_done_q || aw_hs) && (w_done_q || w_hs);

  // Byte strobe for the incoming write request.
  always_comb begin
    wstrb_c = '1;
    if (lsu_w_size_i == 3'd0)      wstrb_c = STRB_W'(1) << w_off;
    else if (lsu_w_size_i == 3'd1) wstrb_c = STRB_W'(3) << w_off;
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next state and state-derived outputs.
  always_comb begin
    state_nxt      = state;
    axi_arvalid_o  = 1'b0;
    axi_rready_o   = 1'b0;
    axi_awvalid_o  = 1'b0;
    axi_wvalid_o   = 1'b0;
    axi_wlast_o    = 1'b0;
    axi_bready_o   = 1'b0;
    lsu_r_ready_o  = 1'b0;
    lsu_r_last_o   = 1'b0;
    lsu_w_last_o   = 1'b0;
    access_fault_o = 1'b0;
    case (state)
      S_IDLE: begin
        if (lsu_r_valid_i)      state_nxt = S_AR;
        else if (lsu_w_valid_i) state_nxt = S_AWW;
      end
      S_AR: begin
        axi_arvalid_o = 1'b1;
        if (axi_arready_i) state_nxt = S_R;
      end
      S_R: begin
        axi_rready_o = 1'b1;
        if (axi_rvalid_i) state_nxt = S_RRESP;
      end
      S_RRESP: begin
        lsu_r_ready_o  = 1'b1;
        lsu_r_last_o   = 1'b1;
        access_fault_o = (resp_q != 2'b00);
        state_nxt      = S_IDLE;
      end
      S_AWW: begin
        axi_awvalid_o = !aw_done_q;
        axi_wvalid_o  = !w_done_q;
        axi_wlast_o   = !w_done_q;
        if (aww_done) state_nxt = S_B;
      end
      S_B: begin
        axi_bready_o = 1'b1;
        if (axi_bvalid_i) state_nxt = S_BRESP;
      end
      S_BRESP: begin
        lsu_w_last_o   = 1'b1;
        access_fault_o = (resp_q != 2'b00);
        state_nxt      = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Request latching, read-data capture and AW/W handshake tracking.
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q    <= '0;
      size_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (lsu_r_valid_i) begin
            addr_q <= lsu_r_addr_i;
            size_q <= clamp_size(lsu_r_size_i);
          end else if (lsu_w_valid_i) begin
            addr_q  <= lsu_w_addr_i;
            size_q  <= clamp_size(lsu_w_size_i);
            wdata_q <= lsu_w_data_i << {w_off, 3'b000};
            wstrb_q <= wstrb_c;
          end
        end
        S_R: begin
          if (axi_rvalid_i) begin
            rdata_q <= axi_rdata_i >> {addr_q[OFF_W-1:0], 3'b000};
            resp_q  <= axi_rresp_i;
          end
        end
        S_AWW: begin
          if (aww_done) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
          end else begin
            aw_done_q <= aw_done_q || aw_hs;
            w_done_q  <= w_done_q || w_hs;
          end
        end
        S_B: begin
          if (axi_bvalid_i) resp_q <= axi_bresp_i;
        end
        default: ;
      endcase
    end
  end

  assign lsu_r_data_o  = rdata_q;
  assign lsu_w_ready_o = w_hs;
  assign axi_araddr_o  = addr_q;
  assign axi_arsize_o  = size_q;
  assign axi_arlen_o   = 8'd0;
  assign axi_awaddr_o  = addr_q;
  assign axi_awsize_o  = size_q;
  assign axi_awlen_o   = 8'd0;
  assign axi_wdata_o   = wdata_q;
  assign axi_wstrb_o   = wstrb_q;

endmodule

// File: tb/tb_ysyx_23060077_lsu_axi_master.sv
// Bench for the LSU/AXI bridge: a stalling AXI slave with its own memory,
// a byte-level reference memory, and a completion scoreboard.
module tb_ysyx_23060077_lsu_axi_master;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clock, reset;
  logic        lsu_r_valid_i, lsu_r_ready_o, lsu_r_last_o;
  logic [31:0] lsu_r_addr_i, lsu_r_data_o;
  logic [2:0]  lsu_r_size_i;
  logic [7:0]  lsu_r_len_i;
  logic        lsu_w_valid_i, lsu_w_ready_o, lsu_w_last_o, access_fault_o;
  logic [31:0] lsu_w_addr_i, lsu_w_data_i;
  logic [2:0]  lsu_w_size_i;
  logic [7:0]  lsu_w_len_i;
  logic        axi_arvalid_o, axi_arready_i;
  logic [31:0] axi_araddr_o;
  logic [2:0]  axi_arsize_o;
  logic [7:0]  axi_arlen_o;
  logic        axi_rvalid_i, axi_rready_o, axi_rlast_i;
  logic [31:0] axi_rdata_i;
  logic [1:0]  axi_rresp_i;
  logic        axi_awvalid_o, axi_awready_i;
  logic [31:0] axi_awaddr_o;
  logic [2:0]  axi_awsize_o;
  logic [7:0]  axi_awlen_o;
  logic        axi_wvalid_o, axi_wready_i, axi_wlast_o;
  logic [31:0] axi_wdata_o;
  logic [3:0]  axi_wstrb_o;
  logic        axi_bvalid_i, axi_bready_o;
  logic [1:0]  axi_bresp_i;

  ysyx_23060077_lsu_axi_master dut (
    .clock(clock), .reset(reset),
    .lsu_r_valid_i(lsu_r_valid_i), .lsu_r_addr_i(lsu_r_addr_i),
    .lsu_r_size_i(lsu_r_size_i), .lsu_r_len_i(lsu_r_len_i),
    .lsu_r_ready_o(lsu_r_ready_o), .lsu_r_last_o(lsu_r_last_o),
    .lsu_r_data_o(lsu_r_data_o),
    .lsu_w_valid_i(lsu_w_valid_i), .lsu_w_addr_i(lsu_w_addr_i),
    .lsu_w_size_i(lsu_w_size_i), .lsu_w_len_i(lsu_w_len_i),
    .lsu_w_data_i(lsu_w_data_i), .lsu_w_ready_o(lsu_w_ready_o),
    .lsu_w_last_o(lsu_w_last_o), .access_fault_o(access_fault_o),
    .axi_arvalid_o(axi_arvalid_o), .axi_arready_i(axi_arready_i),
    .axi_araddr_o(axi_araddr_o), .axi_arsize_o(axi_arsize_o),
    .axi_arlen_o(axi_arlen_o),
    .axi_rvalid_i(axi_rvalid_i), .axi_rready_o(axi_rready_o),
    .axi_rdata_i(axi_rdata_i), .axi_rresp_i(axi_rresp_i),
    .axi_rlast_i(axi_rlast_i),
    .axi_awvalid_o(axi_awvalid_o), .axi_awready_i(axi_awready_i),
    .axi_awaddr_o(axi_awaddr_o), .axi_awsize_o(axi_awsize_o),
    .axi_awlen_o(axi_awlen_o),
    .axi_wvalid_o(axi_wvalid_o), .axi_wready_i(axi_wready_i),
    .axi_wdata_o(axi_wdata_o), .axi_wstrb_o(axi_wstrb_o),
    .axi_wlast_o(axi_wlast_o),
    .axi_bvalid_i(axi_bvalid_i), .axi_bready_o(axi_bready_o),
    .axi_bresp_i(axi_bresp_i)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Scoreboard of expected LSU completions
  typedef struct {
    bit          is_wr;
    logic [31:0] data;
    bit          fault;
  } exp_t;
  exp_t exp_q[$];

  // Reference memory (bytes written by size rules) and slave memory (by strobes)
  logic [31:0] ref_mem [16];
  logic [31:0] s_mem   [16];

  // Slave stall delays and responses set by the driver before each request
  int       ar_d, r_d, aw_d, w_d, b_d;
  logic [1:0] rresp_v, bresp_v;
  // Slave observations
  logic [31:0] s_araddr, s_awaddr, s_wdata;
  logic [2:0]  s_arsize, s_awsize;
  logic [7:0]  s_arlen, s_awlen;
  logic [3:0]  s_wstrb;
  logic        s_wlast;
  int n_ar_hs = 0, n_aw_hs = 0;
  // Per-request activity counters
  int arv_cyc, awv_cyc, wv_cyc, wrdy_n, wrdy_cyc;

  // AXI slave: drives at the falling edge, stalls each channel by its configured delay
  initial begin : slave
    int  ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    bit  r_pend, b_pend, got_aw, got_w;
    axi_arready_i = 0; axi_rvalid_i = 0; axi_rdata_i = '0; axi_rresp_i = '0;
    axi_rlast_i = 0; axi_awready_i = 0; axi_wready_i = 0; axi_bvalid_i = 0;
    axi_bresp_i = '0;
    ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    r_pend = 0; b_pend = 0; got_aw = 0; got_w = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        axi_arready_i = 0; axi_rvalid_i = 0; axi_rlast_i = 0;
        axi_awready_i = 0; axi_wready_i = 0; axi_bvalid_i = 0;
        ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        r_pend = 0; b_pend = 0; got_aw = 0; got_w = 0;
      end else begin
        if (axi_arready_i) axi_arready_i = 0;
        else if (axi_arvalid_o) begin
          if (ar_cnt >= ar_d) begin
            axi_arready_i = 1; ar_cnt = 0; n_ar_hs++;
            s_araddr = axi_araddr_o; s_arsize = axi_arsize_o; s_arlen = axi_arlen_o;
            r_pend = 1; r_cnt = 0;
          end else ar_cnt++;
        end
        if (axi_rvalid_i) begin axi_rvalid_i = 0; axi_rlast_i = 0; end
        else if (r_pend && axi_rready_o) begin
          if (r_cnt >= r_d) begin
            axi_rvalid_i = 1; axi_rlast_i = 1; r_pend = 0;
            axi_rdata_i = s_mem[s_araddr[5:2]]; axi_rresp_i = rresp_v;
          end else r_cnt++;
        end
        if (axi_awready_i) axi_awready_i = 0;
        else if (axi_awvalid_o) begin
          if (aw_cnt >= aw_d) begin
            axi_awready_i = 1; aw_cnt = 0; n_aw_hs++; got_aw = 1;
            s_awaddr = axi_awaddr_o; s_awsize = axi_awsize_o; s_awlen = axi_awlen_o;
          end else aw_cnt++;
        end
        if (axi_wready_i) axi_wready_i = 0;
        else if (axi_wvalid_o) begin
          if (w_cnt >= w_d) begin
            axi_wready_i = 1; w_cnt = 0; got_w = 1;
            s_wdata = axi_wdata_o; s_wstrb = axi_wstrb_o; s_wlast = axi_wlast_o;
          end else w_cnt++;
        end
        if (got_aw && got_w) begin
          for (int b = 0; b < 4; b++)
            if (s_wstrb[b]) s_mem[s_awaddr[5:2]][8*b +: 8] = s_wdata[8*b +: 8];
          got_aw = 0; got_w = 0; b_pend = 1; b_cnt = 0;
        end
        if (axi_bvalid_i) axi_bvalid_i = 0;
        else if (b_pend && axi_bready_o) begin
          if (b_cnt >= b_d) begin
            axi_bvalid_i = 1; axi_bresp_i = bresp_v; b_pend = 0;
          end else b_cnt++;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every completion, counts channel activity
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock); #1;
      if (!reset) begin
        if (axi_arvalid_o) arv_cyc++;
        if (axi_awvalid_o) awv_cyc++;
        if (axi_wvalid_o)  wv_cyc++;
        if (lsu_w_ready_o) begin wrdy_n++; wrdy_cyc = cyc; end
        if (lsu_r_ready_o || lsu_w_last_o) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_completion: got r=%0b w=%0b expected none", lsu_r_ready_o, lsu_w_last_o);
          end else begin
            e = exp_q.pop_front();
            chk("cpl_is_write", 32'(lsu_w_last_o), 32'(e.is_wr));
            chk("cpl_is_read",  32'(lsu_r_ready_o), 32'(!e.is_wr));
            if (!e.is_wr) begin
              chk("r_data", lsu_r_data_o, e.data);
              chk("r_last", 32'(lsu_r_last_o), 32'd1);
            end
            chk("fault", 32'(access_fault_o), 32'(e.fault));
          end
        end else chk("fault_idle", 32'(access_fault_o), 32'd0);
      end
    end
  end

  int n_ar = 0, n_aw = 0;

  task automatic finish_now();
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "stopping after timeout");
  endtask

  // Wait for the completion pulse of the current request; returns its latency
  task automatic wait_cpl(input bit wr, input int start, output int lat);
    bit got = 0;
    repeat (300) if (!got) begin
      @(negedge clock); #1;
      got = wr ? lsu_w_last_o : lsu_r_ready_o;
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL completion_timeout: got none expected pulse (wr=%0b)", wr);
      finish_now();
    end
    lat = cyc - start;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [2:0] size,
                         input logic [1:0] resp, input int ad, input int rd);
    exp_t e; int start, lat;
    assert ((addr & ((32'd1 << size) - 1)) == 0) else $error("misaligned read %h", addr);
    e.is_wr = 0;
    e.data  = ref_mem[addr[5:2]] >> (8 * int'(addr[1:0]));
    e.fault = (resp != 2'b00);
    exp_q.push_back(e);
    ar_d = ad; r_d = rd; rresp_v = resp; arv_cyc = 0; n_ar++;
    lsu_r_addr_i = addr; lsu_r_size_i = size; lsu_r_valid_i = 1; start = cyc;
    wait_cpl(0, start, lat);
    @(negedge clock); #1;
    lsu_r_valid_i = 0;
    chk("r_latency", 32'(lat), 32'(3 + ad + rd));
    chk("arvalid_cycles", 32'(arv_cyc), 32'(ad + 1));
    chk("araddr", s_araddr, addr);
    chk("arsize", 32'(s_arsize), 32'(size));
    chk("arlen", 32'(s_arlen), 32'd0);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] data,
                          input logic [1:0] resp, input int awd, input int wd, input int bd);
    exp_t e; int start, lat, off, n; logic [3:0] es;
    assert ((addr & ((32'd1 << (size > 2 ? 2 : size)) - 1)) == 0) else $error("misaligned write %h", addr);
    off = int'(addr[1:0]);
    n   = (size >= 3'd2) ? 4 : (1 << size);
    es  = '0;
    for (int i = 0; i < n; i++) begin
      es[off + i] = 1'b1;
      ref_mem[addr[5:2]][8*(off + i) +: 8] = data[8*i +: 8];
    end
    e.is_wr = 1; e.data = '0; e.fault = (resp != 2'b00);
    exp_q.push_back(e);
    aw_d = awd; w_d = wd; b_d = bd; bresp_v = resp;
    awv_cyc = 0; wv_cyc = 0; wrdy_n = 0; wrdy_cyc = 0; n_aw++;
    lsu_w_addr_i = addr; lsu_w_size_i = size; lsu_w_data_i = data; lsu_w_valid_i = 1; start = cyc;
    wait_cpl(1, start, lat);
    @(negedge clock); #1;
    lsu_w_valid_i = 0;
    chk("w_latency", 32'(lat), 32'(3 + (awd > wd ? awd : wd) + bd));
    chk("awvalid_cycles", 32'(awv_cyc), 32'(awd + 1));
    chk("wvalid_cycles", 32'(wv_cyc), 32'(wd + 1));
    chk("w_ready_pulses", 32'(wrdy_n), 32'd1);
    chk("w_ready_cycle", 32'(wrdy_cyc - start), 32'(wd + 1));
    chk("awaddr", s_awaddr, addr);
    chk("wdata", s_wdata, data << (8 * off));
    chk("wstrb", 32'(s_wstrb), 32'(es));
    chk("wlast", 32'(s_wlast), 32'd1);
    chk("awlen", 32'(s_awlen), 32'd0);
    if (size <= 3'd2) chk("awsize", 32'(s_awsize), 32'(size));
  endtask

  function automatic logic [1:0] rand_resp();
    return ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
  endfunction

  initial begin : driver
    bit got;
    reset = 1;
    lsu_r_valid_i = 0; lsu_r_addr_i = '0; lsu_r_size_i = '0; lsu_r_len_i = '0;
    lsu_w_valid_i = 0; lsu_w_addr_i = '0; lsu_w_size_i = '0; lsu_w_len_i = '0; lsu_w_data_i = '0;
    ar_d = 0; r_d = 0; aw_d = 0; w_d = 0; b_d = 0; rresp_v = 0; bresp_v = 0;
    for (int i = 0; i < 16; i++) begin ref_mem[i] = $urandom; s_mem[i] = ref_mem[i]; end
    ref_mem[0] = 32'hAABB_CCDD; s_mem[0] = 32'hAABB_CCDD;

    repeat (3) @(negedge clock);
    #1;
    chk("reset_ctrl_outputs",
        32'({lsu_r_ready_o, lsu_r_last_o, lsu_w_ready_o, lsu_w_last_o, access_fault_o,
             axi_arvalid_o, axi_rready_o, axi_awvalid_o, axi_wvalid_o, axi_wlast_o, axi_bready_o}), 32'd0);
    chk("reset_r_data", lsu_r_data_o, 32'd0);
    chk("reset_araddr", axi_araddr_o, 32'd0);
    chk("reset_wdata", axi_wdata_o, 32'd0);
    chk("reset_wstrb", 32'(axi_wstrb_o), 32'd0);
    reset = 0;

    // lb at offset 3, zero wait
    do_read(BASE + 32'd3, 3'd0, 2'b00, 0, 0);
    // sh at offset 2, zero wait
    do_write(BASE + 32'd2, 3'd1, 32'h0000_1234, 2'b00, 0, 0, 0);
    // lh reads back the halfword just written
    do_read(BASE + 32'd2, 3'd1, 2'b00, 0, 0);
    // AR stalled 2, R stalled 3
    do_read(BASE + 32'd4, 3'd2, 2'b00, 2, 3);
    // AW immediate, W stalled 3
    do_write(BASE + 32'd8, 3'd2, 32'hCAFE_F00D, 2'b00, 0, 3, 0);
    // W first, AW late, B stalled
    do_write(BASE + 32'd12, 3'd0, 32'h0000_005A, 2'b00, 2, 0, 2);
    // Error response on lw, then a normal lw
    do_read(BASE + 32'd8, 3'd2, 2'b10, 0, 0);
    do_read(BASE + 32'd8, 3'd2, 2'b00, 0, 0);
    // Error response on a write
    do_write(BASE + 32'd16, 3'd2, 32'h1111_2222, 2'b11, 1, 1, 1);
    // Oversized write behaves as a word write
    do_write(BASE + 32'd20, 3'd3, 32'h89AB_CDEF, 2'b00, 0, 0, 0);
    do_read(BASE + 32'd20, 3'd2, 2'b00, 0, 0);

    // Reset while waiting in R, then a fresh lw from IDLE
    ar_d = 0; r_d = 200; rresp_v = 0; n_ar++;
    lsu_r_addr_i = BASE + 32'd24; lsu_r_size_i = 3'd2; lsu_r_valid_i = 1;
    got = 0;
    repeat (20) if (!got) begin @(negedge clock); #1; got = axi_rready_o; end
    chk("reached_r_state", 32'(got), 32'd1);
    reset = 1;
    @(negedge clock); #1;
    reset = 0; lsu_r_valid_i = 0;
    chk("mid_reset_outputs",
        32'({axi_arvalid_o, axi_rready_o, axi_awvalid_o, axi_wvalid_o, axi_bready_o,
             lsu_r_ready_o, lsu_w_last_o, lsu_w_ready_o, access_fault_o}), 32'd0);
    do_read(BASE + 32'd24, 3'd2, 2'b00, 0, 0);

    // Random mix of aligned reads and writes with random stalls and responses
    for (int t = 0; t < 60; t++) begin
      logic [2:0]  sz;
      logic [31:0] a;
      int          off;
      sz  = 3'($urandom_range(0, 2));
      off = (sz == 3'd0) ? int'($urandom_range(0, 3)) : (sz == 3'd1) ? 2 * int'($urandom_range(0, 1)) : 0;
      a   = BASE + 32'(4 * $urandom_range(0, 15)) + 32'(off);
      if ($urandom_range(0, 1) == 0)
        do_read(a, sz, rand_resp(), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      else
        do_write(a, sz, $urandom, rand_resp(), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    repeat (5) @(negedge clock);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    chk("ar_handshake_count", 32'(n_ar_hs), 32'(n_ar));
    chk("aw_handshake_count", 32'(n_aw_hs), 32'(n_aw));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
